// File: rtl/bargraph_scheduler.sv
// bargraph_scheduler
// Round-robin time-sharing of the 8-LED bar graph between three byte sources.
// Each grant is held for DWELL TICKs and is followed by GAP blank TICKs. The
// granted byte is shown raw, as a thermometer bar, or as a single dot.
// All state advances only on CCLK edges where TICK is high.
module bargraph_scheduler #(
   parameter int unsigned DWELL = 8,
   parameter int unsigned GAP   = 1
) (
   input  logic       CCLK,
   input  logic       RSTN,
   input  logic       TICK,
   input  logic [2:0] REQ,
   input  logic [7:0] DATA0,
   input  logic [7:0] DATA1,
   input  logic [7:0] DATA2,
   input  logic [1:0] MODE,
   output logic [2:0] GNT,
   output logic [7:0] LD,
   output logic       BUSY
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SHOW = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam logic [7:0] C_DWELL_M1 = 8'(DWELL - 1);
   localparam bit         C_HAS_GAP  = (GAP != 0);
   localparam logic [7:0] C_GAP_M1   = C_HAS_GAP ? 8'(GAP - 1) : 8'd0;

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [1:0]  r_last;
   logic [1:0]  r_win;
   logic [2:0]  r_gnt;
   logic [7:0]  r_ld;
   logic        r_busy;

   logic        w_found;
   logic [1:0]  w_next;
   logic [7:0]  w_next_data;
   logic [7:0]  w_cur_data;
   logic [2:0]  w_grant_gnt;
   logic [7:0]  w_grant_ld;
   logic [7:0]  w_show_ld;
   logic        w_show_exit;

   // Byte formatter: raw, thermometer bar up to bit n, single dot at bit n, blank
   function automatic logic [7:0] fmt(input logic [7:0] d, input logic [1:0] m);
      logic [7:0] y;
      logic [2:0] n;
      y = '0;
      n = d[7:5];
      case (m)
         2'b00: y = d;
         2'b01: begin
            if (d != '0) begin
               for (int unsigned i = 0; i < 8; i++) begin
                  y[i] = (i <= {29'd0, n});
               end
            end
         end
         2'b10: begin
            if (d != '0) y[n] = 1'b1;
         end
         default: y = '0;
      endcase
      return y;
   endfunction

   // Round-robin winner: search starts one past the last grant
   always_comb begin
      w_found = |REQ;
      w_next  = 2'd0;
      case (r_last)
         2'd0: begin
            if (REQ[1])      w_next = 2'd1;
            else if (REQ[2]) w_next = 2'd2;
            else             w_next = 2'd0;
         end
         2'd1: begin
            if (REQ[2])      w_next = 2'd2;
            else if (REQ[0]) w_next = 2'd0;
            else             w_next = 2'd1;
         end
         default: begin
            if (REQ[0])      w_next = 2'd0;
            else if (REQ[1]) w_next = 2'd1;
            else             w_next = 2'd2;
         end
      endcase
   end

   // Data selection for the prospective winner and the current holder
   always_comb begin
      case (w_next)
         2'd0:    w_next_data = DATA0;
         2'd1:    w_next_data = DATA1;
         default: w_next_data = DATA2;
      endcase
      case (r_win)
         2'd0:    w_cur_data = DATA0;
         2'd1:    w_cur_data = DATA1;
         default: w_cur_data = DATA2;
      endcase
   end

   // Values loaded on a grant TICK and on an ordinary SHOW TICK
   always_comb begin
      w_grant_gnt = 3'(3'b001 << w_next);
      w_grant_ld  = fmt(w_next_data, MODE);
      w_show_ld   = fmt(w_cur_data, MODE);
      w_show_exit = (r_cnt == '0) || !REQ[r_win];
   end

   // Scheduler FSM with registered grant, LED and busy outputs
   always_ff @(posedge CCLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_last  <= 2'd2;
         r_win   <= 2'd0;
         r_gnt   <= '0;
         r_ld    <= '0;
         r_busy  <= 1'b0;
      end else if (TICK) begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state <= S_SHOW;
                  r_win   <= w_next;
                  r_last  <= w_next;
                  r_cnt   <= C_DWELL_M1;
                  r_gnt   <= w_grant_gnt;
                  r_ld    <= w_grant_ld;
                  r_busy  <= 1'b1;
               end else begin
                  r_gnt  <= '0;
                  r_ld   <= '0;
                  r_busy <= 1'b0;
               end
            end
            S_SHOW: begin
               if (w_show_exit) begin
                  if (C_HAS_GAP) begin
                     r_state <= S_GAP;
                     r_cnt   <= C_GAP_M1;
                     r_gnt   <= '0;
                     r_ld    <= '0;
                     r_busy  <= 1'b1;
                  end else if (w_found) begin
                     // No gap: re-arbitrate on the same TICK that ends the dwell
                     r_state <= S_SHOW;
                     r_win   <= w_next;
                     r_last  <= w_next;
                     r_cnt   <= C_DWELL_M1;
                     r_gnt   <= w_grant_gnt;
                     r_ld    <= w_grant_ld;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                     r_gnt   <= '0;
                     r_ld    <= '0;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_ld  <= w_show_ld;
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_GAP: begin
               if (r_cnt == '0) begin
                  if (w_found) begin
                     r_state <= S_SHOW;
                     r_win   <= w_next;
                     r_last  <= w_next;
                     r_cnt   <= C_DWELL_M1;
                     r_gnt   <= w_grant_gnt;
                     r_ld    <= w_grant_ld;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_gnt   <= '0;
                     r_ld    <= '0;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_gnt   <= '0;
               r_ld    <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign GNT  = r_gnt;
   assign LD   = r_ld;
   assign BUSY = r_busy;

endmodule

// File: doc/bargraph_scheduler.md
Name: bargraph_scheduler

Overview:
- Time-shares the 8-LED bar graph between three data sources: switch bank, test-pattern generator and an external sample.
- Arbitration is round-robin with a fixed dwell per grant and a blank gap between grants.
- The granted byte is formatted as raw, bar (thermometer) or dot, and driven to LD7..LD0.
- Sits between the clock divider (which supplies TICK) and the LED pins; replaces direct wiring of a single source to the bar graph.

Parameters:
DWELL, 8, number of TICKs a grant is held (1..255)
GAP, 1, number of blank TICKs between grants (0..255; 0 = no blank state)

Ports:
CCLK  input  1  system clock, all state on rising edge
RSTN  input  1  asynchronous active-low reset
TICK  input  1  one-CCLK-wide enable pulse from the divider; all FSM/counter updates only on CCLK edges with TICK=1
REQ   input  3  per-source display request; bit0 switches, bit1 test pattern, bit2 external
DATA0 input  8  source 0 byte
DATA1 input  8  source 1 byte
DATA2 input  8  source 2 byte
MODE  input  2  00 raw, 01 bar, 10 dot, 11 blank
GNT   output 3  one-hot grant, registered
LD    output 8  LED drive, registered, bit7 = LD7
BUSY  output 1  1 when state is SHOW or GAP

Behaviour:
- Reset (RSTN=0, asynchronous): state IDLE, GNT=000, LD=00h, BUSY=0, tick counter=0, last-grant pointer=2 so the first grant goes to source 0.
- Outputs are registered. They change on the CCLK edge where TICK=1 is sampled, never between TICKs.
- States:
  - IDLE: GNT=0, LD=0. On a TICK with REQ!=0, grant the round-robin winner, load counter=DWELL-1, go to SHOW. With REQ=0, stay in IDLE.
  - SHOW:
    - GNT is one-hot to the winner.
    - Each TICK: LD=fmt(DATA[winner],MODE), then decrement the counter.
    - Leave SHOW on a TICK where counter==0 or REQ[winner]=0. Go to GAP (counter=GAP-1) if GAP>0; otherwise go straight to arbitration (same as the IDLE decision on that TICK).
  - GAP: GNT=0, LD=0, BUSY=1. Decrement each TICK. At counter==0, arbitrate: if REQ!=0, go to SHOW with the new winner; else go to IDLE.
- Round-robin: search starts at (last+1) mod 3 and takes the first set REQ bit. last updates on each grant. A single persistent requester is re-granted after each dwell/gap.
- Formatting, with n=data[7:5]:
  - raw: LD=data.
  - bar: data==0 gives LD=00h; otherwise LD bits 0..n are set.
  - dot: data==0 gives LD=00h; otherwise only LD bit n is set.
  - blank: LD=00h.
- MODE and DATA are sampled on every SHOW TICK. Changes appear on the next TICK edge.
- The first SHOW TICK (the grant TICK) also loads LD from the winner's data, giving a latency of one CCLK from the TICK edge.
- Simultaneous counter expiry and REQ drop behave as a single exit.
- REQ of a non-granted source rising mid-dwell does not pre-empt.
- TICK held high continuously is legal; every CCLK then counts as a TICK.
- Reset asserted mid-SHOW clears LD/GNT immediately, without waiting for a CCLK edge.

Test Plan:
- Reset, then REQ=001, DATA0=A5h, MODE=00, DWELL=8, GAP=1 -> on the first TICK GNT=001 and LD=A5h. LD is held for 8 TICKs, then 1 TICK with LD=00/GNT=000, then GNT=001 again.
- REQ=111 held -> grants cycle 001,010,100,001, each SHOW lasting exactly 8 TICKs with BUSY=1 throughout.
- SHOW source1 with MODE=01, DATA1=60h -> LD=0Fh. MODE=10 -> LD=08h. DATA1=00h in bar mode -> LD=00h. MODE=11 -> LD=00h.
- Granted REQ drops at dwell TICK 3 -> exit on that TICK to GAP. With GAP=0 and REQ=000, go directly to IDLE, with LD=00 and BUSY=0 on the same edge.
- Assert RSTN=0 mid-SHOW between TICKs -> LD=00h and GNT=000 asynchronously. After release with REQ=110, the first grant is 010.
- TICK low for 50 cycles while REQ toggles -> no output change. Only TICK edges advance state.
